bist_pattern_engine: RTL and testbench

//  Self-test engine for combinational CUTs built from the N1..N12 cell library.

---
 rtl/bist_pkg.sv | 37 +++
 rtl/bist_shift_xor.sv | 46 ++++
 rtl/bist_pattern_engine.sv | 165 ++++++++++++++++
 tb/tb_bist_pattern_engine.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
// Shared types and helpers for the BIST pattern engine.
//   state_t    : engine FSM states (IDLE, RUN, FLUSH, DONE)
//   POLY_W*    : default maximal-length tap masks for 4, 8 and 16 bit registers
//   lfsr_next  : one Fibonacci step of a feedback shift register of up to
//                MAX_W bits: shift left, feed back the parity of the tapped bits
// -----------------------------------------------------------------------------
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0]  POLY_W4  = 4'h9;
    localparam logic [7:0]  POLY_W8  = 8'hB8;
    localparam logic [15:0] POLY_W16 = 16'hB400;

    // Widest register lfsr_next can handle.
    localparam int MAX_W = 32;

    function automatic logic [MAX_W-1:0] lfsr_next(
        input logic [MAX_W-1:0] val,
        input logic [MAX_W-1:0] poly,
        input int               width
    );
        logic [MAX_W-1:0] mask;
        logic             fb;
        mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
        fb   = ^(val & poly & mask);
        return ((val << 1) | MAX_W'(fb)) & mask;
    endfunction

endpackage

// File: rtl/bist_shift_xor.sv
// -----------------------------------------------------------------------------
// bist_shift_xor
// W-bit feedback shift register with a parallel XOR input. Used both as the
// pattern LFSR (xor_in tied to zero) and as the response MISR (xor_in = CUT
// response).
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (q <= RST_VAL)
//   load       : q <= load_val (priority over en)
//   load_val   : value loaded at the start of a run
//   en         : q <= step(q) ^ xor_in
//   xor_in     : parallel compaction input
//   q          : register contents
// -----------------------------------------------------------------------------
module bist_shift_xor
    import bist_pkg::*;
#(
    parameter int           W       = 8,
    parameter logic [W-1:0] POLY    = '0,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] xor_in,
    output logic [W-1:0] q
);

    logic [W-1:0] step;

    always_comb begin
        step = W'(lfsr_next(MAX_W'(q), MAX_W'(POLY), W));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= step ^ xor_in;
        end
    end

endmodule

// File: rtl/bist_pattern_engine.sv
// -----------------------------------------------------------------------------
// bist_pattern_engine
// Logic BIST for a combinational (optionally pipelined) CUT: an LFSR drives
// NUM_PATTERNS pseudo-random patterns, a MISR compacts the responses, and the
// final signature is compared against GOLDEN_SIG.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   start      : level; begins a run when sampled in IDLE or DONE
//   abort      : return to IDLE on the next edge from any state
//   pat_out    : pattern to the CUT (LFSR register)
//   resp_in    : CUT response, RESP_LAT cycles behind pat_out
//   busy       : high in RUN and FLUSH
//   done       : high in DONE
//   pass       : signature == GOLDEN_SIG, meaningful while done
//   signature  : MISR register
//   pat_count  : patterns issued this run (saturates at NUM_PATTERNS)
//   state_dbg  : current FSM state for observation
//
// Control protocol: there is no valid/ready handshake. start is a level that
// is acted on only in IDLE or DONE and ignored while busy; abort wins over
// start on the same edge and leaves lfsr/misr untouched for post-mortem debug.
// -----------------------------------------------------------------------------
module bist_pattern_engine
    import bist_pkg::*;
#(
    parameter int              IN_W         = 8,
    parameter int              OUT_W        = 4,
    parameter int              NUM_PATTERNS = 255,
    parameter int              RESP_LAT     = 0,
    parameter logic [IN_W-1:0] LFSR_POLY    = POLY_W8,
    parameter logic [OUT_W-1:0] MISR_POLY   = POLY_W4,
    parameter logic [IN_W-1:0] SEED         = 8'h01,
    parameter logic [OUT_W-1:0] GOLDEN_SIG  = 4'h0,
    localparam int             CNT_W        = $clog2(NUM_PATTERNS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [IN_W-1:0]  pat_out,
    input  logic [OUT_W-1:0] resp_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature,
    output logic [CNT_W-1:0] pat_count,
    output state_t           state_dbg
);

    // Elaboration-time parameter checks.
    if (SEED == '0) begin : g_bad_seed
        $error("bist_pattern_engine: SEED must be nonzero");
    end
    if (IN_W < 2 || OUT_W < 2 || NUM_PATTERNS < 1) begin : g_bad_width
        $error("bist_pattern_engine: IN_W/OUT_W must be >=2, NUM_PATTERNS >=1");
    end
    if (RESP_LAT < 0 || RESP_LAT > 7) begin : g_bad_lat
        $error("bist_pattern_engine: RESP_LAT must be 0..7");
    end

    // Keep the valid pipe at least one bit wide so RESP_LAT=0 elaborates.
    localparam int PIPE_W = (RESP_LAT > 0) ? RESP_LAT : 1;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [PIPE_W-1:0] vpipe;
    logic [PIPE_W-1:0] vpipe_next;
    logic              launch;
    logic              run_step;
    logic              last_pat;
    logic              resp_valid;
    logic              misr_en;
    logic [IN_W-1:0]   lfsr_q;
    logic [OUT_W-1:0]  misr_q;

    always_comb begin
        launch     = ((state == IDLE) || (state == DONE)) && start && !abort;
        run_step   = (state == RUN) && !abort;
        last_pat   = (count == CNT_W'(NUM_PATTERNS - 1));
        // A 1 enters the pipe for every RUN cycle; in FLUSH only zeros follow.
        vpipe_next = (vpipe << 1) | PIPE_W'(state == RUN);
        // Delayed valid marks the cycle whose resp_in belongs to an issued
        // pattern; with no latency that is simply the RUN cycle itself.
        resp_valid = (RESP_LAT == 0) ? (state == RUN) : vpipe[PIPE_W-1];
        misr_en    = resp_valid && !abort;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            vpipe <= '0;
        end else if (abort) begin
            // pat_count is kept so the abort point can be read back.
            state <= IDLE;
            vpipe <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        count <= '0;
                        vpipe <= '0;
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    vpipe <= vpipe_next;
                    if (last_pat) begin
                        state <= (RESP_LAT > 0) ? FLUSH : DONE;
                    end
                end
                FLUSH: begin
                    vpipe <= vpipe_next;
                    // Leave on the edge that retires the last delayed valid.
                    if (vpipe_next == '0) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    bist_shift_xor #(
        .W       (IN_W),
        .POLY    (LFSR_POLY),
        .RST_VAL (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (launch),
        .load_val (SEED),
        .en       (run_step),
        .xor_in   ('0),
        .q        (lfsr_q)
    );

    bist_shift_xor #(
        .W       (OUT_W),
        .POLY    (MISR_POLY),
        .RST_VAL ('0)
    ) u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (launch),
        .load_val ('0),
        .en       (misr_en),
        .xor_in   (resp_in),
        .q        (misr_q)
    );

    // All outputs come straight from registers or from a state decode; misr
    // is frozen in DONE, so pass is stable for as long as done is high.
    always_comb begin
        pat_out   = lfsr_q;
        signature = misr_q;
        pat_count = count;
        state_dbg = state;
        busy      = (state == RUN) || (state == FLUSH);
        done      = (state == DONE);
        pass      = (state == DONE) && (misr_q == GOLDEN_SIG);
    end

endmodule

// File: tb/tb_bist_pattern_engine.sv
// -----------------------------------------------------------------------------
// tb_bist_pattern_engine
// Four engine instances share one clock and reset:
//   a : IN_W=4 taps 4'b1001, 20 patterns, no latency (sequence/abort/reset)
//   b : IN_W=8, 10 patterns, GOLDEN_SIG=0 (zero-response and determinism)
//   c : as b but GOLDEN_SIG=1
//   d : IN_W=8, 5 patterns, RESP_LAT=2 behind a modelled pipelined CUT
// Expected patterns and signatures come from arithmetic models of the
// register rules (parity via $countones, pattern lists held in queues).
// -----------------------------------------------------------------------------
module tb_bist_pattern_engine;
    import bist_pkg::*;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    // instance a
    logic       a_start, a_abort, a_busy, a_done, a_pass;
    logic [3:0] a_pat, a_resp, a_sig;
    logic [4:0] a_cnt;
    state_t     a_state;
    // instances b and c share stimulus
    logic       bc_start, bc_abort;
    logic [3:0] bc_resp;
    logic [7:0] b_pat, c_pat;
    logic       b_busy, b_done, b_pass, c_busy, c_done, c_pass;
    logic [3:0] b_sig, c_sig, b_cnt, c_cnt;
    state_t     b_state, c_state;
    // instance d
    logic       d_start, d_abort, d_busy, d_done, d_pass;
    logic [7:0] d_pat;
    logic [3:0] d_resp, d_sig;
    logic [2:0] d_cnt;
    state_t     d_state;

    logic [7:0] a_exp_q[$];

    bist_pattern_engine #(.IN_W(4), .OUT_W(4), .NUM_PATTERNS(20), .RESP_LAT(0),
        .LFSR_POLY(4'h9), .MISR_POLY(4'h9), .SEED(4'h1), .GOLDEN_SIG(4'h0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .pat_out(a_pat),
        .resp_in(a_resp), .busy(a_busy), .done(a_done), .pass(a_pass),
        .signature(a_sig), .pat_count(a_cnt), .state_dbg(a_state));

    bist_pattern_engine #(.IN_W(8), .OUT_W(4), .NUM_PATTERNS(10), .RESP_LAT(0),
        .LFSR_POLY(8'hB8), .MISR_POLY(4'h9), .SEED(8'h01), .GOLDEN_SIG(4'h0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(bc_start), .abort(bc_abort), .pat_out(b_pat),
        .resp_in(bc_resp), .busy(b_busy), .done(b_done), .pass(b_pass),
        .signature(b_sig), .pat_count(b_cnt), .state_dbg(b_state));

    bist_pattern_engine #(.IN_W(8), .OUT_W(4), .NUM_PATTERNS(10), .RESP_LAT(0),
        .LFSR_POLY(8'hB8), .MISR_POLY(4'h9), .SEED(8'h01), .GOLDEN_SIG(4'h1)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(bc_start), .abort(bc_abort), .pat_out(c_pat),
        .resp_in(bc_resp), .busy(c_busy), .done(c_done), .pass(c_pass),
        .signature(c_sig), .pat_count(c_cnt), .state_dbg(c_state));

    bist_pattern_engine #(.IN_W(8), .OUT_W(4), .NUM_PATTERNS(5), .RESP_LAT(2),
        .LFSR_POLY(8'hB8), .MISR_POLY(4'h9), .SEED(8'h5A), .GOLDEN_SIG(4'h0)) dut_d (
        .clk(clk), .rst_n(rst_n), .start(d_start), .abort(d_abort), .pat_out(d_pat),
        .resp_in(d_resp), .busy(d_busy), .done(d_done), .pass(d_pass),
        .signature(d_sig), .pat_count(d_cnt), .state_dbg(d_state));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Shift left by one, append parity of the tapped bits, keep w bits.
    function automatic logic [7:0] reg_step(input logic [7:0] v, input logic [7:0] poly, input int w);
        logic [7:0] mask;
        logic       fb;
        mask = 8'((1 << w) - 1);
        fb   = ($countones(v & poly) % 2) == 1;
        return ((v << 1) | {7'd0, fb}) & mask;
    endfunction

    function automatic logic [3:0] misr_model(input logic [3:0] m, input logic [3:0] r);
        logic [7:0] t;
        t = reg_step({4'd0, m}, 8'h09, 4);
        return t[3:0] ^ r;
    endfunction

    // Combinational CUT behind instance d.
    function automatic logic [3:0] cut_fn(input logic [7:0] p);
        return p[7:4] ^ {p[2:0], p[3]};
    endfunction

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++; if (a_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", a_state, IDLE); end
        checks++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_pass !== 1'b0) begin errors++; $display("FAIL reset_flags: busy=%b done=%b pass=%b expected 000", a_busy, a_done, a_pass); end
        checks++; if (a_pat !== 4'h1) begin errors++; $display("FAIL reset_pat: got %h expected 1", a_pat); end
        checks++; if (a_sig !== 4'h0) begin errors++; $display("FAIL reset_sig: got %h expected 0", a_sig); end
        checks++; if (a_cnt !== 5'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", a_cnt); end
        checks++; if (d_pat !== 8'h5A) begin errors++; $display("FAIL reset_pat_d: got %h expected 5a", d_pat); end
        checks++; if (b_busy !== 1'b0 || c_done !== 1'b0 || d_busy !== 1'b0) begin errors++; $display("FAIL reset_other: b_busy=%b c_done=%b d_busy=%b expected 000", b_busy, c_done, d_busy); end
    endtask

    task automatic test_lfsr_sequence();
        logic [3:0] spec_seq [4];
        logic [3:0] m, r;
        spec_seq = '{4'h1, 4'h3, 4'h7, 4'hF};
        m = '0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            checks++; if (a_pat !== a_exp_q[k][3:0]) begin errors++; $display("FAIL seq_pat[%0d]: got %h expected %h", k, a_pat, a_exp_q[k][3:0]); end
            if (k < 4) begin
                checks++; if (a_pat !== spec_seq[k]) begin errors++; $display("FAIL seq_head[%0d]: got %h expected %h", k, a_pat, spec_seq[k]); end
            end
            if (k == 15) begin
                checks++; if (a_pat !== 4'h1) begin errors++; $display("FAIL seq_period: got %h expected 1", a_pat); end
            end
            checks++; if (a_busy !== 1'b1 || a_cnt !== 5'(k)) begin errors++; $display("FAIL seq_run[%0d]: busy=%b cnt=%0d expected busy=1 cnt=%0d", k, a_busy, a_cnt, k); end
            r = 4'($urandom_range(0, 15));
            a_resp = r;
            m = misr_model(m, r);
            tick();
        end
        checks++; if (a_done !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL seq_done: done=%b busy=%b expected 1 0", a_done, a_busy); end
        checks++; if (a_cnt !== 5'd20) begin errors++; $display("FAIL seq_cnt: got %0d expected 20", a_cnt); end
        checks++; if (a_sig !== m) begin errors++; $display("FAIL seq_sig: got %h expected %h", a_sig, m); end
        checks++; if (a_pass !== (m == 4'h0)) begin errors++; $display("FAIL seq_pass: got %b expected %b", a_pass, (m == 4'h0)); end
        checks++; if (a_pat !== a_exp_q[20][3:0]) begin errors++; $display("FAIL seq_final_pat: got %h expected %h", a_pat, a_exp_q[20][3:0]); end
        a_resp = 4'($urandom_range(0, 15));
        repeat (3) tick();
        checks++; if (a_done !== 1'b1 || a_sig !== m || a_cnt !== 5'd20) begin errors++; $display("FAIL seq_hold: done=%b sig=%h cnt=%0d expected 1 %h 20", a_done, a_sig, a_cnt, m); end
    endtask

    task automatic test_zero_resp();
        int n;
        bc_resp  = 4'h0;
        bc_start = 1'b1;
        tick();
        bc_start = 1'b0;
        n = 0;
        while (b_busy && n < 100) begin
            n++;
            tick();
        end
        checks++; if (n !== 10) begin errors++; $display("FAIL zero_busy_len: got %0d expected 10", n); end
        checks++; if (b_done !== 1'b1 || b_pass !== 1'b1) begin errors++; $display("FAIL zero_pass_b: done=%b pass=%b expected 1 1", b_done, b_pass); end
        checks++; if (b_sig !== 4'h0 || b_cnt !== 4'd10) begin errors++; $display("FAIL zero_sig_cnt: sig=%h cnt=%0d expected 0 10", b_sig, b_cnt); end
        checks++; if (c_done !== 1'b1 || c_pass !== 1'b0 || c_sig !== 4'h0) begin errors++; $display("FAIL zero_golden1: done=%b pass=%b sig=%h expected 1 0 0", c_done, c_pass, c_sig); end
    endtask

    task automatic test_determinism();
        logic [3:0] vals [10];
        logic [3:0] m;
        m = '0;
        for (int k = 0; k < 10; k++) begin
            vals[k] = 4'($urandom_range(0, 15));
            m = misr_model(m, vals[k]);
        end
        for (int run = 0; run < 2; run++) begin
            bc_start = 1'b1;
            tick();
            bc_start = 1'b0;
            for (int k = 0; k < 10; k++) begin
                bc_resp = vals[k];
                tick();
            end
            bc_resp = 4'($urandom_range(0, 15));
            checks++; if (b_done !== 1'b1 || b_sig !== m) begin errors++; $display("FAIL det_b[%0d]: done=%b sig=%h expected 1 %h", run, b_done, b_sig, m); end
            checks++; if (c_done !== 1'b1 || c_sig !== m) begin errors++; $display("FAIL det_c[%0d]: done=%b sig=%h expected 1 %h", run, c_done, c_sig, m); end
            checks++; if (b_pass !== (m == 4'h0) || c_pass !== (m == 4'h1)) begin errors++; $display("FAIL det_pass[%0d]: b=%b c=%b expected %b %b", run, b_pass, c_pass, (m == 4'h0), (m == 4'h1)); end
        end
    endtask

    task automatic test_latency();
        logic [7:0] exp_q[$];
        logic [7:0] p;
        logic [3:0] m;
        p = 8'h5A;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(p);
            p = reg_step(p, 8'hB8, 8);
        end
        m = '0;
        for (int k = 0; k < 5; k++) m = misr_model(m, cut_fn(exp_q[k]));
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        for (int t = 0; t < 7; t++) begin
            checks++; if (d_busy !== 1'b1) begin errors++; $display("FAIL lat_busy[%0d]: got %b expected 1", t, d_busy); end
            checks++; if (d_pat !== exp_q[(t < 5) ? t : 5]) begin errors++; $display("FAIL lat_pat[%0d]: got %h expected %h", t, d_pat, exp_q[(t < 5) ? t : 5]); end
            // Responses before the first delayed valid are junk and must be ignored.
            d_resp = (t >= 2) ? cut_fn(exp_q[t-2]) : 4'($urandom_range(0, 15));
            tick();
        end
        d_resp = 4'($urandom_range(0, 15));
        checks++; if (d_busy !== 1'b0 || d_done !== 1'b1) begin errors++; $display("FAIL lat_done: busy=%b done=%b expected 0 1", d_busy, d_done); end
        checks++; if (d_sig !== m) begin errors++; $display("FAIL lat_sig: got %h expected %h", d_sig, m); end
        checks++; if (d_cnt !== 3'd5 || d_pass !== (m == 4'h0)) begin errors++; $display("FAIL lat_cnt_pass: cnt=%0d pass=%b expected 5 %b", d_cnt, d_pass, (m == 4'h0)); end
    endtask

    task automatic test_abort();
        logic [3:0] m, r;
        int n;
        m = '0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            r = 4'($urandom_range(0, 15));
            a_resp = r;
            m = misr_model(m, r);
            tick();
        end
        a_abort = 1'b1;
        a_start = 1'b1;
        a_resp  = 4'($urandom_range(0, 15));
        tick();
        a_abort = 1'b0;
        a_start = 1'b0;
        checks++; if (a_state !== IDLE || a_busy !== 1'b0 || a_done !== 1'b0 || a_pass !== 1'b0) begin errors++; $display("FAIL abort_idle: state=%0d busy=%b done=%b pass=%b expected 0 0 0 0", a_state, a_busy, a_done, a_pass); end
        checks++; if (a_cnt !== 5'd3) begin errors++; $display("FAIL abort_cnt: got %0d expected 3", a_cnt); end
        checks++; if (a_pat !== a_exp_q[3][3:0] || a_sig !== m) begin errors++; $display("FAIL abort_hold: pat=%h sig=%h expected %h %h", a_pat, a_sig, a_exp_q[3][3:0], m); end
        // start pulse while busy must not restart the run
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        n = 0;
        while (a_busy && n < 100) begin
            a_start = (n == 2) ? 1'b1 : 1'b0;
            a_resp  = 4'($urandom_range(0, 15));
            n++;
            tick();
        end
        a_start = 1'b0;
        checks++; if (n !== 20 || a_done !== 1'b1 || a_cnt !== 5'd20) begin errors++; $display("FAIL busy_start: busy_len=%0d done=%b cnt=%0d expected 20 1 20", n, a_done, a_cnt); end
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        checks++; if (a_done !== 1'b0 || a_pass !== 1'b0 || a_state !== IDLE) begin errors++; $display("FAIL abort_done: done=%b pass=%b state=%0d expected 0 0 0", a_done, a_pass, a_state); end
    endtask

    task automatic test_reset_mid_run();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_pass !== 1'b0 || a_state !== IDLE) begin errors++; $display("FAIL rst_mid_flags: busy=%b done=%b pass=%b state=%0d expected 0 0 0 0", a_busy, a_done, a_pass, a_state); end
        checks++; if (a_pat !== 4'h1 || a_sig !== 4'h0 || a_cnt !== 5'd0) begin errors++; $display("FAIL rst_mid_regs: pat=%h sig=%h cnt=%0d expected 1 0 0", a_pat, a_sig, a_cnt); end
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            checks++; if (a_pat !== a_exp_q[k][3:0]) begin errors++; $display("FAIL rst_rerun_pat[%0d]: got %h expected %h", k, a_pat, a_exp_q[k][3:0]); end
            tick();
        end
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
    endtask

    // ---------------- main ----------------
    initial begin
        logic [7:0] p;
        errors   = 0;
        checks   = 0;
        rst_n    = 1'b0;
        a_start  = 1'b0; a_abort  = 1'b0; a_resp  = 4'h0;
        bc_start = 1'b0; bc_abort = 1'b0; bc_resp = 4'h0;
        d_start  = 1'b0; d_abort  = 1'b0; d_resp  = 4'h0;
        p = 8'h01;
        for (int k = 0; k < 21; k++) begin
            a_exp_q.push_back(p);
            p = reg_step(p, 8'h09, 4);
        end

        test_reset();
        test_lfsr_sequence();
        test_zero_resp();
        test_determinism();
        test_latency();
        test_abort();
        test_reset_mid_run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
